// File: rtl/falcon_pkg.sv
// Shared constants for the Falcon arithmetic datapath over q = 12289 = 3*2^12 + 1.
// SCALE_INV is (-3)^-1 mod q, the pre-scale factor that cancels the K-RED -3.
package falcon_pkg;
    localparam int WIDTH     = 14;
    localparam int Q         = 12289;
    localparam int K         = 3;
    localparam int SCALE_INV = 4096;
    localparam int SPLIT     = 12;
    localparam int PROD_W    = 2 * WIDTH;
    localparam int FOLD_W    = 18;
endpackage

// File: rtl/kred_fold.sv
// K-RED fold: r = c_h - K*c_l for p = c_h*2^12 + c_l, which is congruent to -K*p mod q.
// Purely combinational; the signed result spans -12285..65535.
module kred_fold
    import falcon_pkg::*;
(
    input  logic [PROD_W-1:0]        p,
    output logic signed [FOLD_W-1:0] r
);

    logic [FOLD_W-1:0] c_h;
    logic [FOLD_W-1:0] c_l3;

    always_comb begin
        c_h  = FOLD_W'(p[PROD_W-1:SPLIT]);
        c_l3 = FOLD_W'(p[SPLIT-1:0]) * FOLD_W'(K);
        // Modular subtraction in FOLD_W bits yields the two's-complement result directly.
        r    = signed'(c_h - c_l3);
    end

endmodule

// File: rtl/falcon_kred_modmul.sv
// Pipelined (-3*a*b) mod q multiplier: multiply, fold, reduce; 3-cycle latency, 1 result/cycle.
// No handshake or stall: a new operand pair is taken on every clock.
module falcon_kred_modmul
    import falcon_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c_mod_q
);

    localparam logic [FOLD_W-1:0] Q1 = FOLD_W'(Q);
    localparam logic [FOLD_W-1:0] Q2 = FOLD_W'(2 * Q);
    localparam logic [FOLD_W-1:0] Q3 = FOLD_W'(3 * Q);
    localparam logic [FOLD_W-1:0] Q4 = FOLD_W'(4 * Q);
    localparam logic [FOLD_W-1:0] Q5 = FOLD_W'(5 * Q);

    logic [PROD_W-1:0]        p_d;
    logic [PROD_W-1:0]        p_q;
    logic signed [FOLD_W-1:0] r_d;
    logic signed [FOLD_W-1:0] r_q;
    logic [WIDTH-1:0]         c_mod_d;
    logic [FOLD_W-1:0]        t;
    logic [FOLD_W-1:0]        sub;

    always_comb begin
        p_d = PROD_W'(a) * PROD_W'(b);
    end

    kred_fold u_fold (
        .p (p_q),
        .r (r_d)
    );

    // Lift negatives into 0..65535, then strip the largest multiple of q (at most 5q).
    always_comb begin
        t = r_q[FOLD_W-1] ? unsigned'(r_q) + Q1 : unsigned'(r_q);
        if (t >= Q5) begin
            sub = Q5;
        end else if (t >= Q4) begin
            sub = Q4;
        end else if (t >= Q3) begin
            sub = Q3;
        end else if (t >= Q2) begin
            sub = Q2;
        end else if (t >= Q1) begin
            sub = Q1;
        end else begin
            sub = '0;
        end
        c_mod_d = WIDTH'(t - sub);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q     <= '0;
            r_q     <= '0;
            c_mod_q <= '0;
        end else begin
            p_q     <= p_d;
            r_q     <= r_d;
            c_mod_q <= c_mod_d;
        end
    end

endmodule

// File: tb/tb_falcon_kred_modmul.sv
// Directed-vector bench for falcon_kred_modmul: a hand-computed table, sweeps against a
// reference model, a continuous random stream and a mid-stream asynchronous reset.
module tb_falcon_kred_modmul;
    import falcon_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] a = '0;
    logic [13:0] b = '0;
    logic [13:0] c_mod_q;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    string name_q[$];

    typedef struct {
        int    a;
        int    b;
        int    exp;
        string name;
    } vec_t;

    vec_t vecs[14];

    falcon_kred_modmul dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c_mod_q (c_mod_q)
    );

    always #5 clk = ~clk;

    function automatic int model(int x, int y);
        longint m;
        m = (longint'(x) * longint'(y) * 3) % longint'(Q);
        return int'((longint'(Q) - m) % longint'(Q));
    endfunction

    task automatic check(string name, logic [15:0] got, logic [15:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // One clock: check the result owed for inputs driven three steps ago, then drive new inputs.
    task automatic step(string name, int x, int y, int expv);
        @(negedge clk);
        if (exp_q.size() == 3) begin
            check(name_q.pop_front(), {2'b00, c_mod_q}, 16'(exp_q.pop_front()));
        end
        a = 14'(x);
        b = 14'(y);
        exp_q.push_back(expv);
        name_q.push_back(name);
    endtask

    // Pipeline holds zeros right after reset: the first three outputs are owed as 0.
    task automatic prime();
        exp_q.delete();
        name_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(0);
            name_q.push_back("post_reset_zero");
        end
    endtask

    initial begin
        vecs[0]  = '{0,     0,     0,     "zero_zero"};
        vecs[1]  = '{1,     1,     12286, "unit_1x1"};
        vecs[2]  = '{2,     3,     12271, "unit_2x3"};
        vecs[3]  = '{4096,  1,     1,     "scale_inv_x1"};
        vecs[4]  = '{12288, 12288, 12286, "qm1_sq"};
        vecs[5]  = '{12288, 1,     3,     "qm1_x1"};
        vecs[6]  = '{1,     12288, 3,     "x1_qm1"};
        vecs[7]  = '{16383, 16383, 4080,  "max_sq"};
        vecs[8]  = '{4096,  4096,  4096,  "scale_inv_sq"};
        vecs[9]  = '{4096,  5,     5,     "scale_inv_x5"};
        vecs[10] = '{12289, 1,     0,     "a_eq_q"};
        vecs[11] = '{12290, 2,     12283, "a_qp1_x2"};
        vecs[12] = '{3,     4096,  3,     "x3_scale_inv"};
        vecs[13] = '{12289, 12289, 0,     "q_sq"};

        rst_n = 1'b0;
        a = '0;
        b = '0;
        #12;
        check("reset_state", {2'b00, c_mod_q}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prime();

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        for (int y = 0; y < 1000; y++) step("zero_a", 0, y, 0);
        for (int x = 0; x < 1000; x++) step("zero_b", x, 0, 0);

        for (int x = 4090; x <= 4101; x++)
            for (int y = 4090; y <= 4101; y++)
                step("sweep_4096", x, y, model(x, y));

        for (int x = 0; x < 256; x += 4)
            for (int y = 0; y < 256; y++)
                step("low_grid", x, y, model(x, y));

        for (int x = 12033; x <= 12288; x += 8)
            for (int y = 12033; y <= 12288; y++)
                step("high_grid", x, y, model(x, y));

        for (int i = 0; i < 10000; i++) begin
            int x;
            int y;
            x = int'($urandom_range(0, 16383));
            y = int'($urandom_range(0, 16383));
            step("random_stream", x, y, model(x, y));
        end

        // Mid-stream asynchronous reset with a full pipeline of nonzero results.
        for (int i = 0; i < 5; i++) step("pre_reset_fill", 1, 1, 12286);
        @(posedge clk);
        #2;
        check("pre_reset_value", {2'b00, c_mod_q}, 16'd12286);
        a = 14'd7;
        b = 14'd9;
        rst_n = 1'b0;
        #1;
        check("async_reset", {2'b00, c_mod_q}, 16'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", {2'b00, c_mod_q}, 16'd0);
        end
        @(negedge clk);
        a = '0;
        b = '0;
        rst_n = 1'b1;
        prime();

        for (int i = 0; i < 200; i++) begin
            int x;
            int y;
            x = int'($urandom_range(0, 16383));
            y = int'($urandom_range(0, 16383));
            step("after_reset", x, y, model(x, y));
        end

        for (int i = 0; i < 3; i++) step("drain", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
